keypad_entry_packer: RTL and testbench

- Collects keypad digits for the electronic lock and builds the 6-digit display packet consumed by the display block (`bcd_packet_operacional` / `enable_o` side).
- Handles digit shift-in, backspace, clear, confirm, and inactivity timeout.
- On confirm, emits the entered code to the lock controller and masks the display for a hold period.

---
 rtl/keypad_entry_packer_if.sv | 21 ++
 rtl/keypad_entry_packer.sv | 142 ++++++++++++++
 tb/tb_keypad_entry_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_packer_if.sv
// Keypad key strobe in, display packet and confirmed code out.
// The master drives keys; the slave (the packer) drives the display/code side.
interface keypad_entry_packer_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] bcd_packet;
  logic        enable_o;
  logic [23:0] code;
  logic        code_valid;
  logic [2:0]  digit_count;

  modport master (
    output key_valid, key_code,
    input  bcd_packet, enable_o, code, code_valid, digit_count
  );

  modport slave (
    input  key_valid, key_code,
    output bcd_packet, enable_o, code, code_valid, digit_count
  );
endinterface

// File: rtl/keypad_entry_packer.sv
// Builds the 6-digit lock display packet from keypad strobes; confirms emit the code.
// Latency 1 cycle from key to outputs; no backpressure, a key is accepted every cycle.
module keypad_entry_packer #(
  parameter int MIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int HOLD_CYCLES    = 50_000_000
) (
  input logic                  clk,
  input logic                  rst,
  keypad_entry_packer_if.slave bus
);

  localparam int MAX_CYCLES = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       MIN_COUNT    = 3'(MIN_DIGITS);

  localparam logic [3:0]  KEY_BKSP    = 4'hC;
  localparam logic [3:0]  KEY_CONFIRM = 4'hD;
  localparam logic [3:0]  KEY_CLEAR   = 4'hE;
  localparam logic [23:0] PKT_BLANK   = 24'hBBBBBB;
  localparam logic [23:0] PKT_DASH    = 24'hAAAAAA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      pkt_q, pkt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       count_q, count_d;
  logic [23:0]      code_q, code_d;
  logic             code_vld_q, code_vld_d;
  logic             en_q, en_d;
  logic             is_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pkt_q      <= PKT_BLANK;
      cnt_q      <= '0;
      count_q    <= 3'd0;
      code_q     <= 24'h0;
      code_vld_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    code_d     = code_q;
    code_vld_d = 1'b0;
    is_digit   = (bus.key_code <= 4'd9);

    case (state_q)
      S_IDLE: begin
        if (bus.key_valid && is_digit) begin
          state_d = S_ENTRY;
          pkt_d   = {bus.key_code, 20'hAAAAA};
          count_d = 3'd1;
        end
      end
      S_ENTRY: begin
        // A key of any kind, even an ignored one, beats a timeout in the same cycle.
        if (bus.key_valid) begin
          cnt_d = '0;
          if (is_digit) begin
            if (count_q < 3'd6) begin
              pkt_d   = {bus.key_code, pkt_q[23:4]};
              count_d = count_q + 3'd1;
            end
          end else if (bus.key_code == KEY_BKSP) begin
            if (count_q > 3'd1) begin
              pkt_d   = {pkt_q[19:0], 4'hA};
              count_d = count_q - 3'd1;
            end else if (count_q == 3'd1) begin
              pkt_d   = PKT_DASH;
              count_d = 3'd0;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            state_d = S_IDLE;
            pkt_d   = PKT_BLANK;
            count_d = 3'd0;
          end else if (bus.key_code == KEY_CONFIRM && count_q >= MIN_COUNT) begin
            code_d     = pkt_q;
            code_vld_d = 1'b1;
            state_d    = S_HOLD;
            pkt_d      = PKT_DASH;
            count_d    = 3'd0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
          pkt_d   = PKT_BLANK;
          count_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          pkt_d   = PKT_BLANK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pkt_d   = PKT_BLANK;
        count_d = 3'd0;
      end
    endcase

    // One shared counter: every state change restarts it.
    if (state_d != state_q) cnt_d = '0;
    en_d = (pkt_d != pkt_q);
  end

  always_comb begin
    bus.bcd_packet  = pkt_q;
    bus.enable_o    = en_q;
    bus.code        = code_q;
    bus.code_valid  = code_vld_q;
    bus.digit_count = count_q;
  end

endmodule

// File: tb/tb_keypad_entry_packer.sv
// Directed bench for keypad_entry_packer with short timeout/hold parameters.
module tb_keypad_entry_packer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  keypad_entry_packer_if kif ();

  keypad_entry_packer #(
    .MIN_DIGITS    (4),
    .TIMEOUT_CYCLES(20),
    .HOLD_CYCLES   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = k;
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB) begin
      errors++; $display("FAIL reset_pkt got %h expected bbbbbb", kif.bcd_packet);
    end
    checks++;
    if ({kif.enable_o, kif.code_valid, kif.digit_count} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got en=%b cv=%b cnt=%0d expected 0/0/0",
                         kif.enable_o, kif.code_valid, kif.digit_count);
    end
    checks++;
    if (kif.code !== 24'h0) begin
      errors++; $display("FAIL reset_code got %h expected 000000", kif.code);
    end
    @(negedge clk);
    rst = 1'b0;
    press(4'hD);
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.enable_o !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got %h en=%b expected bbbbbb en=0",
                         kif.bcd_packet, kif.enable_o);
    end
  endtask

  task automatic test_shift_in();
    logic [3:0]  keys [3];
    logic [23:0] exp  [3];
    keys = '{4'h1, 4'h2, 4'h3};
    exp  = '{24'h1AAAAA, 24'h21AAAA, 24'h321AAA};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(keys[i]);
      checks++;
      if (kif.bcd_packet !== exp[i] || kif.enable_o !== 1'b1) begin
        errors++; $display("FAIL shift_pkt[%0d] got %h en=%b expected %h en=1",
                           i, kif.bcd_packet, kif.enable_o, exp[i]);
      end
      tick();
      checks++;
      if (kif.enable_o !== 1'b0) begin
        errors++; $display("FAIL shift_pulse[%0d] got en=%b expected 0", i, kif.enable_o);
      end
    end
    checks++;
    if (kif.digit_count !== 3'd3) begin
      errors++; $display("FAIL shift_count got %0d expected 3", kif.digit_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp [6];
    exp = '{24'h1AAAAA, 24'h21AAAA, 24'h321AAA, 24'h4321AA, 24'h54321A, 24'h654321};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(4'(i + 1));
      checks++;
      if (kif.bcd_packet !== exp[i] || kif.enable_o !== 1'b1) begin
        errors++; $display("FAIL b2b_pkt[%0d] got %h en=%b expected %h en=1",
                           i, kif.bcd_packet, kif.enable_o, exp[i]);
      end
    end
    press(4'h7);
    checks++;
    if (kif.bcd_packet !== 24'h654321 || kif.enable_o !== 1'b0 || kif.digit_count !== 3'd6) begin
      errors++; $display("FAIL full_ignore got %h en=%b cnt=%0d expected 654321 en=0 cnt=6",
                         kif.bcd_packet, kif.enable_o, kif.digit_count);
    end
  endtask

  task automatic test_backspace_clear();
    logic [23:0] exp_pkt [3];
    logic        exp_en  [3];
    logic [2:0]  exp_cnt [3];
    exp_pkt = '{24'h4AAAAA, 24'hAAAAAA, 24'hAAAAAA};
    exp_en  = '{1'b1, 1'b1, 1'b0};
    exp_cnt = '{3'd1, 3'd0, 3'd0};
    do_reset();
    press(4'h4);
    press(4'h5);
    checks++;
    if (kif.bcd_packet !== 24'h54AAAA) begin
      errors++; $display("FAIL bksp_pre got %h expected 54aaaa", kif.bcd_packet);
    end
    for (int i = 0; i < 3; i++) begin
      press(4'hC);
      checks++;
      if (kif.bcd_packet !== exp_pkt[i] || kif.enable_o !== exp_en[i] ||
          kif.digit_count !== exp_cnt[i]) begin
        errors++; $display("FAIL bksp[%0d] got %h en=%b cnt=%0d expected %h en=%b cnt=%0d",
                           i, kif.bcd_packet, kif.enable_o, kif.digit_count,
                           exp_pkt[i], exp_en[i], exp_cnt[i]);
      end
    end
    press(4'hE);
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.enable_o !== 1'b1) begin
      errors++; $display("FAIL clear got %h en=%b expected bbbbbb en=1",
                         kif.bcd_packet, kif.enable_o);
    end
    press(4'hC);
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.enable_o !== 1'b0) begin
      errors++; $display("FAIL clear_idle got %h en=%b expected bbbbbb en=0",
                         kif.bcd_packet, kif.enable_o);
    end
  endtask

  task automatic test_confirm_short();
    do_reset();
    press(4'h9);
    press(4'h8);
    press(4'hD);
    checks++;
    if (kif.bcd_packet !== 24'h89AAAA || kif.enable_o !== 1'b0 || kif.code_valid !== 1'b0) begin
      errors++; $display("FAIL short_confirm got %h en=%b cv=%b expected 89aaaa en=0 cv=0",
                         kif.bcd_packet, kif.enable_o, kif.code_valid);
    end
  endtask

  task automatic test_confirm_hold();
    do_reset();
    press(4'h9);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    press(4'hD);
    checks++;
    if (kif.code_valid !== 1'b1 || kif.code !== 24'h6789AA) begin
      errors++; $display("FAIL confirm_code got cv=%b code=%h expected cv=1 code=6789aa",
                         kif.code_valid, kif.code);
    end
    checks++;
    if (kif.bcd_packet !== 24'hAAAAAA || kif.enable_o !== 1'b1 || kif.digit_count !== 3'd0) begin
      errors++; $display("FAIL confirm_pkt got %h en=%b cnt=%0d expected aaaaaa en=1 cnt=0",
                         kif.bcd_packet, kif.enable_o, kif.digit_count);
    end
    for (int i = 1; i < 8; i++) begin
      if (i == 3) press(4'h2);
      else tick();
      checks++;
      if (kif.bcd_packet !== 24'hAAAAAA || kif.enable_o !== 1'b0 || kif.code_valid !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got %h en=%b cv=%b expected aaaaaa en=0 cv=0",
                           i, kif.bcd_packet, kif.enable_o, kif.code_valid);
      end
    end
    press(4'h5);
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.enable_o !== 1'b1 || kif.digit_count !== 3'd0) begin
      errors++; $display("FAIL hold_end got %h en=%b cnt=%0d expected bbbbbb en=1 cnt=0",
                         kif.bcd_packet, kif.enable_o, kif.digit_count);
    end
    checks++;
    if (kif.code !== 24'h6789AA) begin
      errors++; $display("FAIL code_held got %h expected 6789aa", kif.code);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'h3);
    for (int i = 1; i < 20; i++) tick();
    checks++;
    if (kif.bcd_packet !== 24'h3AAAAA) begin
      errors++; $display("FAIL timeout_early got %h expected 3aaaaa", kif.bcd_packet);
    end
    tick();
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.enable_o !== 1'b1 || kif.digit_count !== 3'd0) begin
      errors++; $display("FAIL timeout got %h en=%b cnt=%0d expected bbbbbb en=1 cnt=0",
                         kif.bcd_packet, kif.enable_o, kif.digit_count);
    end
  endtask

  task automatic test_timeout_key_wins();
    do_reset();
    press(4'h3);
    for (int i = 1; i < 20; i++) tick();
    press(4'h4);
    checks++;
    if (kif.bcd_packet !== 24'h43AAAA || kif.enable_o !== 1'b1) begin
      errors++; $display("FAIL key_wins got %h en=%b expected 43aaaa en=1",
                         kif.bcd_packet, kif.enable_o);
    end
    for (int i = 1; i < 20; i++) tick();
    checks++;
    if (kif.bcd_packet !== 24'h43AAAA) begin
      errors++; $display("FAIL restart_early got %h expected 43aaaa", kif.bcd_packet);
    end
    tick();
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB) begin
      errors++; $display("FAIL restart_timeout got %h expected bbbbbb", kif.bcd_packet);
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'hD);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (kif.bcd_packet !== 24'hBBBBBB || kif.code !== 24'h0 ||
        kif.code_valid !== 1'b0 || kif.enable_o !== 1'b0) begin
      errors++; $display("FAIL hold_rst got pkt=%h code=%h cv=%b en=%b expected bbbbbb/000000/0/0",
                         kif.bcd_packet, kif.code, kif.code_valid, kif.enable_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (kif.code_valid !== 1'b0 || kif.bcd_packet !== 24'hBBBBBB) begin
        errors++; $display("FAIL post_rst[%0d] got cv=%b pkt=%h expected cv=0 pkt=bbbbbb",
                           i, kif.code_valid, kif.bcd_packet);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_shift_in();
    test_back_to_back();
    test_backspace_clear();
    test_confirm_short();
    test_confirm_hold();
    test_timeout();
    test_timeout_key_wins();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
